destuffing: RTL and testbench
=============================

DESTUFFING -- requirements
Module: destuffing

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on rising clock edge.
REQ-003 SHALL have port bitin, input, 1 bit: sampled bus bit from the bit-timing stage (0 = dominant).
REQ-004 SHALL have port activ, input, 1 bit: level strobe from the MAC FSM; one processing event per high phase.
REQ-005 SHALL have port direct, input, 1 bit: destuffing disabled (error frames, interframe); bits are passed through.
REQ-006 SHALL have port clrerr, input, 1 bit: clears the sticky stuff-error flag.
REQ-007 SHALL have port bitout, output, 1 bit: last destuffed data bit, registered.
REQ-008 SHALL have port dataen, output, 1 bit: one-clock pulse when bitout carries a new data bit.
REQ-009 SHALL have port stuff, output, 1 bit: level; last processed bit was a stuff bit and was discarded.
REQ-010 SHALL have port stferr, output, 1 bit: sticky stuff-error flag (six equal consecutive bits).
REQ-011 SHALL have port runcnt, output, 3 bits: current equal-bit run length, range 0..5.

Function
REQ-012 SHALL keep an internal edge flag edged: cleared when activ=0; a processing event occurs in the clock where activ=1 and edged=0, and edged is then set to 1.
REQ-013 SHALL hold all outputs except dataen stable in clocks without a processing event; dataen SHALL be 0 in every clock without an event.
REQ-014 Event, direct=1: SHALL set bitout=bitin, dataen=1, stuff=0, count=0, and leave stferr unchanged; direct has priority over all other rules.
REQ-015 Event, direct=0, count=0: SHALL set buf=bitin, count=1, bitout=bitin, dataen=1, stuff=0.
REQ-016 Event, direct=0, count in 1..4, bitin=buf: SHALL set count=count+1, bitout=bitin, dataen=1, stuff=0.
REQ-017 Event, direct=0, count in 1..4, bitin!=buf: SHALL set buf=bitin, count=1, bitout=bitin, dataen=1, stuff=0.
REQ-018 Event, direct=0, count=5, bitin!=buf (stuff bit): SHALL set stuff=1, dataen=0, buf=bitin, count=1, and leave bitout unchanged.
REQ-019 Event, direct=0, count=5, bitin=buf (stuff error): SHALL set stferr=1, stuff=0, dataen=0, count=0, and leave bitout unchanged.
REQ-020 The stuff bit SHALL count as the first bit of a new run, so 5 equal bits after a stuff bit trigger the next stuff check.
REQ-021 count SHALL never exceed 5, and runcnt SHALL equal count at all times.
REQ-022 clrerr=1 SHALL clear stferr in the same clock; if an error event (REQ-019) occurs in the same clock, the set SHALL win.
REQ-023 direct toggling SHALL take effect only at processing events; an event with direct=1 SHALL restart run counting from 0.

Reset
REQ-024 reset=1 SHALL force bitout=1, dataen=0, stuff=0, stferr=0, count=0, buf=0, edged=0, overriding all other inputs, including activ and clrerr.
REQ-025 After reset, if activ is already high in the first clock with reset=0, that clock SHALL be a processing event.
REQ-026 reset asserted mid-run SHALL discard the partial run; no stuff or error state SHALL survive it.

Verification
REQ-027 Bench SHALL cover: bits 0,0,0,0,0 then 1, each with one activ pulse -> five dataen pulses with bitout=0; sixth event gives stuff=1, dataen=0, bitout=0, runcnt=1.
REQ-028 Bench SHALL cover: bits 1 x5 then 1 -> sixth event gives stferr=1, runcnt=0, no dataen pulse; clrerr pulse -> stferr=0 next clock.
REQ-029 Bench SHALL cover: activ held high for 4 clocks with bitin=0 -> exactly one event, one dataen pulse, runcnt=1.
REQ-030 Bench SHALL cover: direct=1 with bits 0 x7 -> seven dataen pulses, stuff=0, stferr=0, runcnt=0 throughout.
REQ-031 Bench SHALL cover: reset=1 asserted after 3 equal bits -> bitout=1, runcnt=0, stuff=0, stferr=0 next clock; with activ high on release, the first clock is processed.
REQ-032 Bench SHALL cover: clrerr=1 in the same clock as a stuff-error event -> stferr=1 afterwards.

Source files
------------

// File: rtl/destuffing.sv
// ---------------------------------------------------------------------------
// destuffing
//   Bit destuffer for a CAN-style serial receiver. Each high phase of activ
//   is one processing event. On an event the sampled bus bit is either
//   passed on as a data bit, dropped as a stuff bit (after five equal bits),
//   or flagged as a stuff error (six equal bits). With direct high,
//   destuffing is bypassed and every bit is passed through.
//
// Ports
//   clock  in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   bitin  in   sampled bus bit (0 = dominant)
//   activ  in   level strobe, one event per high phase
//   direct in   bypass destuffing (error frames, interframe space)
//   clrerr in   clears the sticky stuff-error flag
//   bitout out  last destuffed data bit (registered)
//   dataen out  one-clock pulse when bitout carries a new data bit
//   stuff  out  last processed bit was a discarded stuff bit (level)
//   stferr out  sticky stuff-error flag
//   runcnt out  current equal-bit run length, 0..5
// ---------------------------------------------------------------------------
module destuffing (
  input  logic       clock,
  input  logic       reset,
  input  logic       bitin,
  input  logic       activ,
  input  logic       direct,
  input  logic       clrerr,
  output logic       bitout,
  output logic       dataen,
  output logic       stuff,
  output logic       stferr,
  output logic [2:0] runcnt
);

  logic       edged_r;
  logic       buf_r;
  logic [2:0] count_r;
  logic       bitout_r;
  logic       dataen_r;
  logic       stuff_r;
  logic       stferr_r;

  logic       event_s;
  logic       err_s;
  logic       buf_s;
  logic [2:0] count_s;
  logic       bitout_s;
  logic       dataen_s;
  logic       stuff_s;
  logic       stferr_s;

  // Next-state computation for one processing event (or hold when idle).
  always_comb begin
    event_s  = activ & ~edged_r;
    err_s    = 1'b0;
    buf_s    = buf_r;
    count_s  = count_r;
    bitout_s = bitout_r;
    dataen_s = 1'b0;
    stuff_s  = stuff_r;

    if (event_s) begin
      if (direct) begin
        // Bypass: pass the bit through and restart run counting.
        bitout_s = bitin;
        dataen_s = 1'b1;
        stuff_s  = 1'b0;
        count_s  = 3'd0;
      end else begin
        case (count_r)
          3'd0: begin
            buf_s    = bitin;
            count_s  = 3'd1;
            bitout_s = bitin;
            dataen_s = 1'b1;
            stuff_s  = 1'b0;
          end
          3'd1, 3'd2, 3'd3, 3'd4: begin
            if (bitin == buf_r) begin
              count_s = count_r + 3'd1;
            end else begin
              buf_s   = bitin;
              count_s = 3'd1;
            end
            bitout_s = bitin;
            dataen_s = 1'b1;
            stuff_s  = 1'b0;
          end
          3'd5: begin
            if (bitin != buf_r) begin
              // Stuff bit: dropped, but it opens the next run.
              stuff_s = 1'b1;
              buf_s   = bitin;
              count_s = 3'd1;
            end else begin
              // Sixth equal bit: stuff error.
              err_s   = 1'b1;
              stuff_s = 1'b0;
              count_s = 3'd0;
            end
          end
          default: begin
            // Counter values above 5 cannot occur; recover to an empty run.
            count_s = 3'd0;
            stuff_s = 1'b0;
          end
        endcase
      end
    end else begin
      dataen_s = 1'b0;
    end

    // A new error in this clock wins over a simultaneous clear.
    if (err_s) begin
      stferr_s = 1'b1;
    end else if (clrerr) begin
      stferr_s = 1'b0;
    end else begin
      stferr_s = stferr_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      edged_r  <= 1'b0;
      buf_r    <= 1'b0;
      count_r  <= 3'd0;
      bitout_r <= 1'b1;
      dataen_r <= 1'b0;
      stuff_r  <= 1'b0;
      stferr_r <= 1'b0;
    end else begin
      // edged tracks activ: set by the event, cleared when activ drops.
      edged_r  <= activ;
      buf_r    <= buf_s;
      count_r  <= count_s;
      bitout_r <= bitout_s;
      dataen_r <= dataen_s;
      stuff_r  <= stuff_s;
      stferr_r <= stferr_s;
    end
  end

  assign bitout = bitout_r;
  assign dataen = dataen_r;
  assign stuff  = stuff_r;
  assign stferr = stferr_r;
  assign runcnt = count_r;

endmodule

// File: tb/tb_destuffing.sv
// ---------------------------------------------------------------------------
// tb_destuffing
//   Self-checking bench for destuffing. Each vector is one clock: inputs are
//   driven, the expected outputs are pushed to a scoreboard queue, and after
//   the rising edge the head of the queue is popped and compared.
// ---------------------------------------------------------------------------
module tb_destuffing;

  logic       clock = 1'b0;
  logic       reset;
  logic       bitin;
  logic       activ;
  logic       direct;
  logic       clrerr;
  logic       bitout;
  logic       dataen;
  logic       stuff;
  logic       stferr;
  logic [2:0] runcnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       act;
    logic       bin;
    logic       dir;
    logic       clr;
    logic       bo;
    logic       de;
    logic       st;
    logic       se;
    logic [2:0] rc;
  } vec_t;

  typedef struct {
    logic       bo;
    logic       de;
    logic       st;
    logic       se;
    logic [2:0] rc;
    string      tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  destuffing dut (
    .clock  (clock),
    .reset  (reset),
    .bitin  (bitin),
    .activ  (activ),
    .direct (direct),
    .clrerr (clrerr),
    .bitout (bitout),
    .dataen (dataen),
    .stuff  (stuff),
    .stferr (stferr),
    .runcnt (runcnt)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic r, a, b, d, c, bo, de, st, se,
                              input logic [2:0] rc);
    vec_t v;
    v.rst = r; v.act = a; v.bin = b; v.dir = d; v.clr = c;
    v.bo = bo; v.de = de; v.st = st; v.se = se; v.rc = rc;
    return v;
  endfunction

  // One activ pulse: event clock, then an idle clock where only dataen drops.
  task automatic pulse(input logic b, d, bo, de, st, se, input logic [2:0] rc);
    tbl.push_back(mk(1'b0, 1'b1, b, d, 1'b0, bo, de, st, se, rc));
    tbl.push_back(mk(1'b0, 1'b0, b, d, 1'b0, bo, 1'b0, st, se, rc));
  endtask

  task automatic chk(input string tag, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    reset  = v.rst;
    activ  = v.act;
    bitin  = v.bin;
    direct = v.dir;
    clrerr = v.clr;
    e.bo = v.bo; e.de = v.de; e.st = v.st; e.se = v.se; e.rc = v.rc; e.tag = tag;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected entry", tag);
    end else begin
      got = sb.pop_front();
      chk(got.tag, "bitout", int'(bitout), int'(got.bo));
      chk(got.tag, "dataen", int'(dataen), int'(got.de));
      chk(got.tag, "stuff",  int'(stuff),  int'(got.st));
      chk(got.tag, "stferr", int'(stferr), int'(got.se));
      chk(got.tag, "runcnt", int'(runcnt), int'(got.rc));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; activ = 1'b0; bitin = 1'b0; direct = 1'b0; clrerr = 1'b0;

    // Reset dominates activ and clrerr.
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    // Five dominant bits, then a recessive stuff bit.
    for (int i = 1; i <= 5; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'(i));
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
    // The stuff bit opens a run: four more ones reach 5, then a 0 is stuffed.
    for (int i = 2; i <= 5; i++) pulse(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(i));
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
    pulse(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
    // Six recessive bits: stuff error.
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    for (int i = 1; i <= 5; i++) pulse(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(i));
    pulse(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    // A direct event leaves the error flag alone; clrerr clears it.
    pulse(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0);
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
    // Direct mode: seven zeros all pass, no stuffing.
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    for (int i = 0; i < 7; i++) pulse(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
    pulse(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // activ held high for four clocks: exactly one event.
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), "held_rst");
    apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1), "held_c1");
    for (int i = 2; i <= 4; i++)
      apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1), $sformatf("held_c%0d", i));
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1), "held_end");

    // Reset mid-run, released with activ already high.
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), "mid_rst0");
    for (int i = 1; i <= 3; i++) begin
      apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'(i)), $sformatf("mid_ev%0d", i));
      apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'(i)), $sformatf("mid_id%0d", i));
    end
    apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), "mid_rst");
    apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1), "mid_first");
    apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1), "mid_hold");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1), "mid_end");

    // clrerr coincident with the error event: set wins; reset clears it.
    apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), "clr_rst");
    for (int i = 1; i <= 5; i++) begin
      apply(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(i)), $sformatf("clr_ev%0d", i));
      apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'(i)), $sformatf("clr_id%0d", i));
    end
    apply(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0), "clr_err");
    apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0), "clr_after");
    apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), "clr_reset");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
